// File: rtl/nary_gate_pipe.sv
// Pipelined bank of LANES run-time-configurable N_IN-input gates.
// Two valid/ready stages (capture, compute) plus a saturating output transfer counter.
module nary_gate_pipe #(
  parameter int N_IN  = 3,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*N_IN-1:0] a,
  input  logic [2:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      y,
  output logic [CNT_W-1:0]      res_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // One lane's gate function; v[0] is the operand for the single-input modes.
  function automatic logic gate_eval(input logic [N_IN-1:0] v, input logic [2:0] m);
    logic r;
    r = 1'b0;
    case (m)
      3'd0:    r = &v;
      3'd1:    r = ~&v;
      3'd2:    r = |v;
      3'd3:    r = ~|v;
      3'd4:    r = ^v;
      3'd5:    r = ~^v;
      3'd6:    r = v[0];
      3'd7:    r = ~v[0];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic                  s1_valid;
  logic [LANES*N_IN-1:0] s1_a;
  logic [2:0]            s1_mode;
  logic                  s2_ready;
  logic                  in_xfer;
  logic                  s1_xfer;
  logic                  out_xfer;
  logic [LANES-1:0]      y_next;

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign in_xfer  = in_valid && in_ready;
  assign s1_xfer  = s1_valid && s2_ready;
  assign out_xfer = out_valid && out_ready;

  // Evaluate every lane from the captured stage-1 operands.
  always_comb begin
    y_next = '0;
    for (int k = 0; k < LANES; k++) begin
      y_next[k] = gate_eval(s1_a[k*N_IN +: N_IN], s1_mode);
    end
  end

  // Stage 1: capture operands and mode together so each item keeps its own function.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_mode  <= 3'd0;
    end else begin
      if (in_xfer) begin
        s1_valid <= 1'b1;
        s1_a     <= a;
        s1_mode  <= mode;
      end else if (s1_xfer) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: result register; y holds while stalled or empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else begin
      if (s1_xfer) begin
        out_valid <= 1'b1;
        y         <= y_next;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Output transfer counter; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cnt <= '0;
    end else begin
      if (out_xfer && (res_cnt != CNT_MAX)) begin
        res_cnt <= res_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_nary_gate_pipe.sv
// Self-checking bench for nary_gate_pipe: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_nary_gate_pipe;
  localparam int N_IN  = 3;
  localparam int LANES = 4;
  localparam int CNT_W = 16;
  localparam int W     = LANES * N_IN;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [W-1:0]     a = '0;
  logic [2:0]       mode = 3'd0;
  logic             in_ready, out_valid;
  logic [LANES-1:0] y;
  logic [CNT_W-1:0] res_cnt;
  logic             sat_in_ready, sat_out_valid;
  logic [LANES-1:0] sat_y;
  logic [2:0]       sat_res_cnt;

  nary_gate_pipe #(.N_IN(N_IN), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .res_cnt(res_cnt));

  nary_gate_pipe #(.N_IN(N_IN), .LANES(LANES), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready), .a(a), .mode(mode),
    .out_valid(sat_out_valid), .out_ready(out_ready), .y(sat_y), .res_cnt(sat_res_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0] y;
    int               t;
  } item_t;

  item_t            q[$];
  int               now = 0;
  int               cnt = 0;
  logic [LANES-1:0] last_y = '0;
  int               checks = 0;
  int               errors = 0;
  logic [7:0]       mode_tbl = 8'b0110_0110;

  // Reference: count ones in each lane and apply the mode's rule.
  function automatic logic [LANES-1:0] ref_y(input logic [W-1:0] av, input logic [2:0] m);
    logic [LANES-1:0] r;
    logic [N_IN-1:0]  v;
    int               ones;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      v    = av[k*N_IN +: N_IN];
      ones = $countones(v);
      case (m)
        3'd0:    r[k] = (ones == N_IN);
        3'd1:    r[k] = (ones != N_IN);
        3'd2:    r[k] = (ones > 0);
        3'd3:    r[k] = (ones == 0);
        3'd4:    r[k] = (ones % 2 == 1);
        3'd5:    r[k] = (ones % 2 == 0);
        3'd6:    r[k] = v[0];
        default: r[k] = ~v[0];
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h at cycle %0d", tag, got, exp, now);
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic tick(output logic acc);
    logic             e_ov, e_rdy;
    logic [LANES-1:0] e_y;
    item_t            it;
    @(negedge clk);
    e_ov  = (q.size() > 0) && (q[0].t + 2 <= now);
    e_rdy = (q.size() < 2) || out_ready;
    e_y   = e_ov ? q[0].y : last_y;
    chk("in_ready", in_ready, e_rdy);
    chk("out_valid", out_valid, e_ov);
    chk("y", y, e_y);
    chk("res_cnt", res_cnt, cnt);
    chk("sat_res_cnt", sat_res_cnt, (cnt > 7) ? 7 : cnt);
    acc = in_valid && e_rdy;
    if (e_ov && out_ready) begin
      last_y = q[0].y;
      void'(q.pop_front());
      cnt++;
    end
    if (acc) begin
      it.y = ref_y(a, mode);
      it.t = now;
      q.push_back(it);
    end
    @(posedge clk);
    now++;
    #1;
  endtask

  task automatic send(input logic [W-1:0] av, input logic [2:0] m, input logic ordy);
    logic acc;
    logic done;
    done      = 1'b0;
    in_valid  = 1'b1;
    a         = av;
    mode      = m;
    out_ready = ordy;
    for (int i = 0; i < 20 && !done; i++) begin
      tick(acc);
      done = acc;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    in_valid  = 1'b0;
    out_ready = ordy;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  // Asynchronous reset asserted away from the clock edge, released just after one.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_res_cnt", res_cnt, 32'd0);
    chk("rst_in_ready", in_ready, 32'd1);
    q.delete();
    cnt    = 0;
    last_y = '0;
    @(posedge clk);
    now++;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic         acc;
    logic [W-1:0] av;

    // Power-on reset
    #3;
    chk("por_out_valid", out_valid, 32'd0);
    chk("por_y", y, 32'd0);
    chk("por_res_cnt", res_cnt, 32'd0);
    chk("por_in_ready", in_ready, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2, 1'b1);

    // NAND3 truth table, streaming back to back
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < LANES; k++) av[k*N_IN +: N_IN] = 3'((i + k) % 8);
      send(av, 3'd1, 1'b1);
    end
    idle(3, 1'b1);
    chk("nand_res_cnt", res_cnt, 32'd8);

    // Every mode on v=101 in all lanes
    for (int m = 0; m < 8; m++) begin
      send({LANES{3'b101}}, 3'(m), 1'b0);
      idle(1, 1'b0);
      chk("mode_tbl_y", y, {LANES{mode_tbl[m]}});
      idle(1, 1'b1);
    end
    idle(2, 1'b1);

    // Backpressure: two accepted, the third waits
    send(12'h111, 3'd4, 1'b0);
    send(12'h222, 3'd2, 1'b0);
    in_valid = 1'b1;
    a        = 12'h3a5;
    mode     = 3'd5;
    for (int i = 0; i < 4; i++) tick(acc);
    chk("bp_in_ready", in_ready, 32'd0);
    chk("bp_out_valid", out_valid, 32'd1);
    send(12'h3a5, 3'd5, 1'b1);
    send(12'hfff, 3'd0, 1'b1);
    send(12'h6c9, 3'd7, 1'b1);
    idle(4, 1'b1);

    // Reset with two items in flight
    send(12'h0f0, 3'd3, 1'b0);
    send(12'h7e1, 3'd6, 1'b0);
    mid_reset();
    send(12'h5a5, 3'd1, 1'b1);
    idle(1, 1'b0);
    chk("post_rst_y", y, {28'd0, ref_y(12'h5a5, 3'd1)});
    idle(3, 1'b1);
    chk("post_rst_res_cnt", res_cnt, 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      a         = W'($urandom);
      mode      = 3'($urandom);
      out_ready = 1'($urandom_range(0, 2) != 0);
      tick(acc);
    end
    idle(4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
